// File: rtl/fft_bin_detect_param_if.sv
// Sample/threshold/result bus between the front-end, the FFT bin detector and the decision logic.
interface fft_bin_detect_param_if #(
    parameter int unsigned DW    = 17,
    parameter int unsigned AW    = 23,
    parameter int unsigned NBINS = 24
);
    logic                    PushIn;
    logic                    FirstData;
    logic signed [DW-1:0]    DinR;
    logic signed [DW-1:0]    DinI;
    logic                    ThrWe;
    logic [1:0]              ThrSel;
    logic [AW-1:0]           ThrVal;
    logic                    Busy;
    logic                    Dropped;
    logic                    Ovf;
    logic                    PushOut;
    logic [2*NBINS-1:0]      DataOut;

    // Producer side: drives samples and thresholds, receives status and results
    modport master (
        output PushIn, FirstData, DinR, DinI, ThrWe, ThrSel, ThrVal,
        input  Busy, Dropped, Ovf, PushOut, DataOut
    );

    // Detector side
    modport slave (
        input  PushIn, FirstData, DinR, DinI, ThrWe, ThrSel, ThrVal,
        output Busy, Dropped, Ovf, PushOut, DataOut
    );
endinterface

// File: rtl/fft_bin_detect_param.sv
// N-point radix-2 DIT FFT (one butterfly per clock, in place) followed by
// per-bin energy classification against three programmable thresholds.
module fft_bin_detect_param #(
    parameter int unsigned LOG2N     = 7,
    parameter int unsigned DW        = 17,
    parameter int unsigned AW        = 23,
    parameter int unsigned BIN_FIRST = 4,
    parameter int unsigned BIN_STEP  = 2,
    parameter int unsigned NBINS     = 24
) (
    input  logic                   Clk,
    input  logic                   Reset,
    fft_bin_detect_param_if.slave  bus
);
    localparam int unsigned N    = 1 << LOG2N;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned PW   = 2 * AW;
    localparam int unsigned BW   = LOG2N - 1;
    localparam int unsigned SW   = 4;
    localparam int unsigned MW   = $clog2(NBINS + 1);
    localparam int unsigned LW   = 2 * NBINS;

    localparam logic signed [PW-1:0] SMAX = {{(PW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = ~SMAX;
    localparam logic [PW-1:0]        EMAX = {{(PW-AW){1'b0}}, {AW{1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FFT, S_DETECT, S_OUT} state_t;

    state_t                 state_q, state_d;
    logic [LOG2N-1:0]       idx_q, idx_d;
    logic [SW-1:0]          stage_q, stage_d;
    logic [BW-1:0]          bfly_q, bfly_d;
    logic [MW-1:0]          det_q, det_d;
    logic [AW-1:0]          e_q, e_d;
    logic [LW-1:0]          levels_q, levels_d;
    logic [LW-1:0]          dout_q, dout_d;
    logic                   push_q, push_d;
    logic                   busy_q, busy_d;
    logic                   drop_q, drop_d;
    logic                   ovf_q, ovf_d;
    logic [AW-1:0]          thr_q [3];
    logic [AW-1:0]          thr_d [3];

    logic signed [AW-1:0]   mem_re_q [N];
    logic signed [AW-1:0]   mem_im_q [N];

    logic                   wa_en, wb_en;
    logic [LOG2N-1:0]       wa_addr, wb_addr;
    logic signed [AW-1:0]   wa_re, wa_im, wb_re, wb_im;

    logic signed [15:0]     tw_re [HALF];
    logic signed [15:0]     tw_im [HALF];

    // Twiddle ROM W^k = exp(-j*2*pi*k/N) in Q1.15, +1.0 clamped to 32767
    for (genvar g = 0; g < HALF; g++) begin : g_tw
        localparam real ANG = 6.283185307179586 * real'(g) / real'(N);
        localparam int  CR  = $rtoi($floor($cos(ANG) * 32768.0 + 0.5));
        localparam int  CI  = $rtoi($floor(-$sin(ANG) * 32768.0 + 0.5));
        assign tw_re[g] = 16'((CR > 32767) ? 32767 : CR);
        assign tw_im[g] = 16'((CI > 32767) ? 32767 : CI);
    end

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = x[LOG2N-1-i];
        end
        return r;
    endfunction

    // Returns {saturated_flag, value clipped to AW signed}
    function automatic logic [AW:0] sat_f(input logic signed [PW-1:0] x);
        if (x > SMAX) begin
            return {1'b1, SMAX[AW-1:0]};
        end else if (x < SMIN) begin
            return {1'b1, SMIN[AW-1:0]};
        end
        return {1'b0, x[AW-1:0]};
    endfunction

    logic [LOG2N-1:0]       bz, lo_mask, addr_a, addr_b;
    logic [BW-1:0]          tw_k;
    logic signed [PW-1:0]   ar, ai, br, bi, wr, wi, pr, pi, tr, ti;
    logic [AW:0]            s_ar, s_ai, s_br, s_bi;
    logic                   bfly_ovf;

    // Butterfly address generation and complex multiply-accumulate
    always_comb begin
        bz      = LOG2N'(bfly_q);
        lo_mask = (LOG2N'(1) << stage_q) - LOG2N'(1);
        addr_a  = ((bz >> stage_q) << (stage_q + SW'(1))) | (bz & lo_mask);
        addr_b  = addr_a | (LOG2N'(1) << stage_q);
        tw_k    = BW'((bz & lo_mask) << (SW'(LOG2N - 1) - stage_q));
        ar      = PW'(mem_re_q[addr_a]);
        ai      = PW'(mem_im_q[addr_a]);
        br      = PW'(mem_re_q[addr_b]);
        bi      = PW'(mem_im_q[addr_b]);
        wr      = PW'(tw_re[tw_k]);
        wi      = PW'(tw_im[tw_k]);
        pr      = br * wr - bi * wi;
        pi      = br * wi + bi * wr;
        tr      = pr >>> 15;
        ti      = pi >>> 15;
        s_ar    = sat_f(ar + tr);
        s_ai    = sat_f(ai + ti);
        s_br    = sat_f(ar - tr);
        s_bi    = sat_f(ai - ti);
        bfly_ovf = s_ar[AW] | s_ai[AW] | s_br[AW] | s_bi[AW];
    end

    logic [LOG2N-1:0]       bin_addr;
    logic signed [PW-1:0]   dr, di, dr2, di2;
    logic [PW-1:0]          esum, eshift;
    logic [AW-1:0]          e_sat;
    logic [1:0]             lvl;

    // Bin energy (saturated) and threshold classification of the registered energy
    always_comb begin
        bin_addr = LOG2N'(BIN_FIRST + int'(det_q) * BIN_STEP);
        dr       = PW'(mem_re_q[bin_addr]);
        di       = PW'(mem_im_q[bin_addr]);
        dr2      = dr * dr;
        di2      = di * di;
        esum     = $unsigned(dr2) + $unsigned(di2);
        eshift   = esum >> 15;
        e_sat    = (eshift > EMAX) ? EMAX[AW-1:0] : eshift[AW-1:0];
        lvl      = 2'd3;
        if (e_q < thr_q[2]) lvl = 2'd2;
        if (e_q < thr_q[1]) lvl = 2'd1;
        if (e_q < thr_q[0]) lvl = 2'd0;
    end

    // Next-state, memory write and output computation
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stage_d  = stage_q;
        bfly_d   = bfly_q;
        det_d    = det_q;
        e_d      = e_q;
        levels_d = levels_q;
        dout_d   = dout_q;
        push_d   = 1'b0;
        ovf_d    = ovf_q;
        thr_d    = thr_q;
        drop_d   = bus.PushIn && (state_q == S_FFT || state_q == S_DETECT);
        wa_en    = 1'b0;
        wb_en    = 1'b0;
        wa_addr  = '0;
        wb_addr  = addr_b;
        wa_re    = AW'(bus.DinR);
        wa_im    = AW'(bus.DinI);
        wb_re    = s_br[AW-1:0];
        wb_im    = s_bi[AW-1:0];

        if (bus.ThrWe && bus.ThrSel != 2'd3) begin
            thr_d[bus.ThrSel] = bus.ThrVal;
        end

        case (state_q)
            S_IDLE, S_OUT: begin
                if (state_q == S_OUT) begin
                    dout_d  = levels_q;
                    push_d  = 1'b1;
                    state_d = S_IDLE;
                end
                if (bus.PushIn && bus.FirstData) begin
                    wa_en   = 1'b1;
                    wa_addr = '0;
                    idx_d   = LOG2N'(1);
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.PushIn) begin
                    wa_en = 1'b1;
                    if (bus.FirstData) begin
                        wa_addr = '0;
                        idx_d   = LOG2N'(1);
                    end else begin
                        wa_addr = bitrev(idx_q);
                        idx_d   = idx_q + LOG2N'(1);
                        if (idx_q == LOG2N'(N - 1)) begin
                            state_d = S_FFT;
                            stage_d = '0;
                            bfly_d  = '0;
                            ovf_d   = 1'b0;
                        end
                    end
                end
            end
            S_FFT: begin
                wa_en   = 1'b1;
                wb_en   = 1'b1;
                wa_addr = addr_a;
                wa_re   = s_ar[AW-1:0];
                wa_im   = s_ai[AW-1:0];
                ovf_d   = ovf_q | bfly_ovf;
                bfly_d  = bfly_q + BW'(1);
                if (bfly_q == BW'(HALF - 1)) begin
                    if (stage_q == SW'(LOG2N - 1)) begin
                        state_d = S_DETECT;
                        det_d   = '0;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end
            end
            S_DETECT: begin
                if (det_q < MW'(NBINS)) begin
                    e_d = e_sat;
                end
                if (det_q != '0) begin
                    levels_d[2 * (int'(det_q) - 1) +: 2] = lvl;
                end
                det_d = det_q + MW'(1);
                if (det_q == MW'(NBINS)) begin
                    state_d = S_OUT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_FFT) || (state_d == S_DETECT);
    end

    // Control, status and result registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            stage_q  <= '0;
            bfly_q   <= '0;
            det_q    <= '0;
            e_q      <= '0;
            levels_q <= '0;
            dout_q   <= '0;
            push_q   <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
            ovf_q    <= 1'b0;
            thr_q[0] <= AW'(885);
            thr_q[1] <= AW'(8159);
            thr_q[2] <= AW'(22749);
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            stage_q  <= stage_d;
            bfly_q   <= bfly_d;
            det_q    <= det_d;
            e_q      <= e_d;
            levels_q <= levels_d;
            dout_q   <= dout_d;
            push_q   <= push_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            thr_q    <= thr_d;
        end
    end

    // Sample/butterfly storage, two write ports
    always_ff @(posedge Clk) begin
        if (wa_en) begin
            mem_re_q[wa_addr] <= wa_re;
            mem_im_q[wa_addr] <= wa_im;
        end
        if (wb_en) begin
            mem_re_q[wb_addr] <= wb_re;
            mem_im_q[wb_addr] <= wb_im;
        end
    end

    assign bus.Busy    = busy_q;
    assign bus.Dropped = drop_q;
    assign bus.Ovf     = ovf_q;
    assign bus.PushOut = push_q;
    assign bus.DataOut = dout_q;
endmodule

// File: tb/tb_fft_bin_detect_param.sv
// Scoreboard bench for fft_bin_detect_param with default parameters.
module tb_fft_bin_detect_param;
    localparam int unsigned LOG2N = 7;
    localparam int unsigned N     = 128;
    localparam int unsigned DW    = 17;
    localparam int unsigned AW    = 23;
    localparam int unsigned NBINS = 24;
    localparam int          LAT   = LOG2N * N / 2 + NBINS + 2;

    typedef struct {
        logic [47:0] data;
        bit          chk_data;
        bit          ovf;
        int          due;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   pushes   = 0;
    int   drops    = 0;
    bit   pw_chk   = 1'b0;
    exp_t sb[$];
    int   fr_re[N];
    int   fr_im[N];

    fft_bin_detect_param_if #(.DW(DW), .AW(AW), .NBINS(NBINS)) bus ();

    fft_bin_detect_param #(
        .LOG2N(LOG2N), .DW(DW), .AW(AW), .BIN_FIRST(4), .BIN_STEP(2), .NBINS(NBINS)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Result monitor: pops the scoreboard on every PushOut
    always @(negedge Clk) begin
        exp_t e;
        if (pw_chk) begin
            check_val("pushout_width", 64'(bus.PushOut), 64'(0));
            pw_chk = 1'b0;
        end else if (bus.PushOut === 1'b1) begin
            pushes++;
            pw_chk = 1'b1;
            check_val("sb_nonempty", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_data) check_val("dataout", 64'(bus.DataOut), 64'(e.data));
                check_val("ovf", 64'(bus.Ovf), 64'(e.ovf));
                check_val("latency", 64'(cyc), 64'(e.due));
            end
        end
        if (bus.Dropped === 1'b1) drops++;
    end

    task automatic send_frame(input int nsamp);
        for (int i = 0; i < nsamp; i++) begin
            bus.PushIn    = 1'b1;
            bus.FirstData = (i == 0);
            bus.DinR      = DW'(fr_re[i]);
            bus.DinI      = DW'(fr_im[i]);
            @(posedge Clk); #1;
        end
        bus.PushIn    = 1'b0;
        bus.FirstData = 1'b0;
    endtask

    task automatic expect_frame(input logic [47:0] d, input bit chk_d, input bit ovf);
        exp_t e;
        e.data = d; e.chk_data = chk_d; e.ovf = ovf; e.due = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge Clk); #1;
            t++;
        end
        check_val("drain", 64'(sb.size()), 64'(0));
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic set_thr(input logic [1:0] sel, input int val);
        bus.ThrWe = 1'b1; bus.ThrSel = sel; bus.ThrVal = AW'(val);
        @(posedge Clk); #1;
        bus.ThrWe = 1'b0;
    endtask

    task automatic fill_const(input int re, input int im);
        for (int i = 0; i < N; i++) begin
            fr_re[i] = re; fr_im[i] = im;
        end
    endtask

    task automatic fill_impulse();
        fill_const(0, 0);
        fr_re[0] = 'h4000;
    endtask

    initial begin
        int d0;
        int p0;
        bus.PushIn = 1'b0; bus.FirstData = 1'b0; bus.DinR = '0; bus.DinI = '0;
        bus.ThrWe = 1'b0; bus.ThrSel = '0; bus.ThrVal = '0;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check_val("rst_busy",    64'(bus.Busy),    64'(0));
        check_val("rst_dropped", 64'(bus.Dropped), 64'(0));
        check_val("rst_ovf",     64'(bus.Ovf),     64'(0));
        check_val("rst_pushout", 64'(bus.PushOut), 64'(0));
        check_val("rst_dataout", 64'(bus.DataOut), 64'(0));
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;

        // Impulse: flat spectrum at 16384, E=8192 -> level 2 everywhere
        fill_impulse(); send_frame(N); expect_frame(48'hAAAA_AAAA_AAAA, 1, 0); wait_drain();

        // All-zero frame
        fill_const(0, 0); send_frame(N); expect_frame(48'h0, 1, 0); wait_drain();

        // Cosine at bin 8, amplitude 256 -> only bin 8 (m=2) reaches level 2
        for (int i = 0; i < N; i++) begin
            fr_re[i] = $rtoi($floor(256.0 * $cos(6.283185307179586 * 8.0 * real'(i) / 128.0) + 0.5));
            fr_im[i] = 0;
        end
        send_frame(N); expect_frame(48'h0000_0000_0020, 1, 0); wait_drain();

        // Threshold programming: each level reachable
        set_thr(2'd0, 9000);
        fill_impulse(); send_frame(N); expect_frame(48'h0, 1, 0); wait_drain();
        set_thr(2'd0, 885);
        set_thr(2'd1, 9000);
        send_frame(N); expect_frame(48'h5555_5555_5555, 1, 0); wait_drain();
        set_thr(2'd1, 8159);
        set_thr(2'd2, 8000);
        send_frame(N); expect_frame(48'hFFFF_FFFF_FFFF, 1, 0); wait_drain();
        set_thr(2'd2, 22749);
        set_thr(2'd3, 0);
        send_frame(N); expect_frame(48'hAAAA_AAAA_AAAA, 1, 0); wait_drain();

        // Full-scale DC saturates the last stages; then a clean frame clears Ovf
        fill_const('hFFFF, 0); send_frame(N); expect_frame(48'h0, 0, 1); wait_drain();
        fill_const(0, 0); send_frame(N); expect_frame(48'h0, 1, 0); wait_drain();

        // Samples during Busy are dropped and leave the result untouched
        fill_impulse(); send_frame(N); expect_frame(48'hAAAA_AAAA_AAAA, 1, 0);
        repeat (10) @(posedge Clk);
        #1;
        d0 = drops;
        for (int i = 0; i < 5; i++) begin
            bus.PushIn = 1'b1; bus.FirstData = (i % 2 == 0); bus.DinR = DW'(1000); bus.DinI = DW'(-1000);
            @(posedge Clk); #1;
        end
        bus.PushIn = 1'b0; bus.FirstData = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check_val("dropped_count", 64'(drops - d0), 64'(5));
        wait_drain();

        // Reset 100 cycles into FFT aborts the frame and clears DataOut
        fill_impulse(); send_frame(N);
        repeat (100) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check_val("abort_dataout", 64'(bus.DataOut), 64'(0));
        check_val("abort_busy",    64'(bus.Busy),    64'(0));
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        p0 = pushes;
        repeat (600) @(posedge Clk);
        #1;
        check_val("abort_no_pushout", 64'(pushes), 64'(p0));

        // FirstData mid-LOAD restarts: 50 junk samples then a full impulse frame
        for (int i = 0; i < 50; i++) begin
            fr_re[i] = int'($urandom_range(0, 20000)) - 10000;
            fr_im[i] = int'($urandom_range(0, 20000)) - 10000;
        end
        send_frame(50);
        fill_impulse(); send_frame(N); expect_frame(48'hAAAA_AAAA_AAAA, 1, 0); wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
